// File: rtl/far_path_pkg.sv
// far_path_pkg
//   Types and constants shared by the far-path normalise/round pipeline.
//   round_mode_e : rounding mode encoding carried alongside each operand
//   ADJ_W        : width of the normalisation left-shift amount (0..2)
package far_path_pkg;

    typedef enum logic [1:0] {
        RNE = 2'd0,
        RTZ = 2'd1,
        RUP = 2'd2,
        RDN = 2'd3
    } round_mode_e;

    localparam int ADJ_W = 2;

endpackage

// File: rtl/far_path_round.sv
// far_path_round
//   Purely combinational mantissa rounding.
//   Ports:
//     kept   in  WIDTH  truncated mantissa (1.M)
//     guard  in  1      first bit below the kept bits
//     sticky in  1      OR of every bit below guard
//     mode   in  2      rounding mode
//     sign   in  1      result sign (directed modes)
//     mant   out WIDTH  rounded mantissa, 1.000.. on carry-out
//     carry  out 1      rounding overflowed the mantissa
module far_path_round
    import far_path_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0] kept,
    input  logic             guard,
    input  logic             sticky,
    input  round_mode_e      mode,
    input  logic             sign,
    output logic [WIDTH-1:0] mant,
    output logic             carry
);

    logic             inc;
    logic [WIDTH:0]   sum;

    always_comb begin
        case (mode)
            RNE:     inc = guard & (sticky | kept[0]);
            RTZ:     inc = 1'b0;
            RUP:     inc = (guard | sticky) & ~sign;
            RDN:     inc = (guard | sticky) & sign;
            default: inc = 1'b0;
        endcase
    end

    assign sum   = {1'b0, kept} + {{WIDTH{1'b0}}, inc};
    assign carry = sum[WIDTH];
    // An all-ones mantissa rolls over to zero; renormalise to 1.000..
    assign mant  = carry ? {1'b1, {(WIDTH-1){1'b0}}} : sum[WIDTH-1:0];

endmodule

// File: rtl/far_path_pipe.sv
// far_path_pipe
//   Elastic pipeline that normalises the far-path adder result (left shift
//   by 0..2), rounds it, and computes the final exponent with saturation to
//   infinity. STAGES (1..3) sets the register depth.
//   Ports:
//     clk, rst                      clock, async active-high reset
//     in_valid/in_ready             operand handshake
//     unnormalized_mantissa         aligned mantissa sum/difference
//     inter_rounding_bits           bits shifted out during alignment
//     exp_inter, sign_i, round_mode operand exponent, sign, rounding mode
//     out_valid/out_ready           result handshake
//     resulted_m_o, resulted_e_o    rounded mantissa, result exponent
//     sign_o, overflow_o, inexact_o result sign and exception flags
//   Build option: FAR_PATH_EXC_FLAGS_EN enables overflow_o/inexact_o;
//   otherwise both read 0 (saturation still applies).
module far_path_pipe
    import far_path_pkg::*;
#(
    parameter int SIZE_IN_MANTISSA  = 24,
    parameter int SIZE_OUT_MANTISSA = 24,
    parameter int SIZE_EXPONENT     = 8,
    parameter int STAGES            = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SIZE_IN_MANTISSA:0]     unnormalized_mantissa,
    input  logic [SIZE_IN_MANTISSA-1:0]   inter_rounding_bits,
    input  logic [SIZE_EXPONENT:0]        exp_inter,
    input  logic                          sign_i,
    input  logic [1:0]                    round_mode,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SIZE_OUT_MANTISSA-1:0]  resulted_m_o,
    output logic [SIZE_EXPONENT-1:0]      resulted_e_o,
    output logic                          sign_o,
    output logic                          overflow_o,
    output logic                          inexact_o
);

    localparam int NW = 2 * SIZE_IN_MANTISSA + 1;
    localparam int OW = SIZE_OUT_MANTISSA;
    localparam int EW = SIZE_EXPONENT;
    localparam logic [EW+2:0] E_MAX = {3'b000, {EW{1'b1}}};

    typedef struct packed {
        logic [OW-1:0]    kept;
        logic             g;
        logic             s;
        logic [EW:0]      exp;
        logic [ADJ_W-1:0] adj;
        logic             sign;
        round_mode_e      mode;
    } norm_t;

    typedef struct packed {
        logic [OW-1:0]    mant;
        logic             carry;
        logic             lost;
        logic [EW:0]      exp;
        logic [ADJ_W-1:0] adj;
        logic             sign;
    } rnd_t;

    typedef struct packed {
        logic [OW-1:0] mant;
        logic [EW-1:0] exp;
        logic          sign;
        logic          ovf;
        logic          inx;
    } res_t;

    norm_t n_comb, n_src;
    rnd_t  r_comb, r_src;
    res_t  f_d, f_q;

    // Handshake: rdy[k] means stage k may load this cycle.
    logic [STAGES-1:0] v;
    logic [STAGES:0]   vld;
    logic [STAGES:0]   rdy;

    assign vld         = {v, in_valid};
    assign rdy[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_rdy
        assign rdy[k] = ~v[k] | rdy[k+1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) v[k] <= vld[k];
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v[STAGES-1];

    // Normalise
    logic [NW-1:0]    joined, shifted, tail;
    logic [ADJ_W-1:0] adj;

    always_comb begin
        if (unnormalized_mantissa[SIZE_IN_MANTISSA])
            adj = ADJ_W'(0);
        else if (unnormalized_mantissa[SIZE_IN_MANTISSA-1])
            adj = ADJ_W'(1);
        else
            adj = ADJ_W'(2);
        joined      = {unnormalized_mantissa, inter_rounding_bits};
        shifted     = joined << adj;
        tail        = shifted << (OW + 1);
        n_comb.kept = shifted[NW-1 -: OW];
        n_comb.g    = shifted[NW-1-OW];
        n_comb.s    = |tail;
        n_comb.exp  = exp_inter;
        n_comb.adj  = adj;
        n_comb.sign = sign_i;
        n_comb.mode = round_mode_e'(round_mode);
    end

    // Round
    logic [OW-1:0] rnd_mant;
    logic          rnd_carry;

    far_path_round #(.WIDTH(OW)) u_round (
        .kept   (n_src.kept),
        .guard  (n_src.g),
        .sticky (n_src.s),
        .mode   (n_src.mode),
        .sign   (n_src.sign),
        .mant   (rnd_mant),
        .carry  (rnd_carry)
    );

    always_comb begin
        r_comb.mant  = rnd_mant;
        r_comb.carry = rnd_carry;
        r_comb.lost  = n_src.g | n_src.s;
        r_comb.exp   = n_src.exp;
        r_comb.adj   = n_src.adj;
        r_comb.sign  = n_src.sign;
    end

    // Stage placement
    if (STAGES == 1) begin : g_s1
        assign n_src = n_comb;
        assign r_src = r_comb;
    end else if (STAGES == 2) begin : g_s2
        norm_t n_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                    n_q <= '0;
            else if (rdy[0] & vld[0])   n_q <= n_comb;
        end
        assign n_src = n_q;
        assign r_src = r_comb;
    end else if (STAGES == 3) begin : g_s3
        norm_t n_q;
        rnd_t  r_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                n_q <= '0;
                r_q <= '0;
            end else begin
                if (rdy[0] & vld[0]) n_q <= n_comb;
                if (rdy[1] & vld[1]) r_q <= r_comb;
            end
        end
        assign n_src = n_q;
        assign r_src = r_q;
    end else begin : g_bad
        $error("far_path_pipe: STAGES must be 1..3");
    end

    // Exponent and saturation. The extra top bits catch wrap below zero,
    // which must not be mistaken for overflow.
    logic [EW+2:0] e_sum;
    logic          ovf;

    always_comb begin
        e_sum = {2'b00, r_src.exp} + (EW+3)'(1) + (EW+3)'(r_src.carry)
              - (EW+3)'(r_src.adj);
        ovf   = ~e_sum[EW+2] & (e_sum >= E_MAX);
        f_d.mant = ovf ? {1'b1, {(OW-1){1'b0}}} : r_src.mant;
        f_d.exp  = ovf ? {EW{1'b1}} : e_sum[EW-1:0];
        f_d.sign = r_src.sign;
`ifdef FAR_PATH_EXC_FLAGS_EN
        f_d.ovf  = ovf;
        f_d.inx  = r_src.lost | ovf;
`else
        f_d.ovf  = 1'b0;
        f_d.inx  = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 f_q <= '0;
        else if (rdy[STAGES-1] & vld[STAGES-1])  f_q <= f_d;
    end

    assign resulted_m_o = f_q.mant;
    assign resulted_e_o = f_q.exp;
    assign sign_o       = f_q.sign;
    assign overflow_o   = f_q.ovf;
    assign inexact_o    = f_q.inx;

endmodule

// File: tb/tb_far_path_pipe.sv
module tb_far_path_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] unnormalized_mantissa;
    logic [23:0] inter_rounding_bits;
    logic [8:0]  exp_inter;
    logic        sign_i;
    logic [1:0]  round_mode;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] resulted_m_o;
    logic [7:0]  resulted_e_o;
    logic        sign_o;
    logic        overflow_o;
    logic        inexact_o;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    far_path_pipe #(
        .SIZE_IN_MANTISSA  (24),
        .SIZE_OUT_MANTISSA (24),
        .SIZE_EXPONENT     (8),
        .STAGES            (2)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .unnormalized_mantissa (unnormalized_mantissa),
        .inter_rounding_bits   (inter_rounding_bits),
        .exp_inter             (exp_inter),
        .sign_i                (sign_i),
        .round_mode            (round_mode),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .resulted_m_o          (resulted_m_o),
        .resulted_e_o          (resulted_e_o),
        .sign_o                (sign_o),
        .overflow_o            (overflow_o),
        .inexact_o             (inexact_o)
    );

`ifdef FAR_PATH_EXC_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [24:0] um, input logic [23:0] irb,
                         input logic [8:0] ex, input logic s, input logic [1:0] rm);
        unnormalized_mantissa = um;
        inter_rounding_bits   = irb;
        exp_inter             = ex;
        sign_i                = s;
        round_mode            = rm;
        in_valid              = 1'b1;
    endtask

    // Single operation with out_ready held high; returns the result and
    // the number of clock edges from accept to out_valid.
    task automatic run_op(input logic [24:0] um, input logic [23:0] irb,
                          input logic [8:0] ex, input logic s, input logic [1:0] rm,
                          output logic [23:0] m, output logic [7:0] e,
                          output logic so, output logic ovf, output logic inx,
                          output int lat);
        @(negedge clk);
        drive(um, irb, ex, s, rm);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        m   = resulted_m_o;
        e   = resulted_e_o;
        so  = sign_o;
        ovf = overflow_o;
        inx = inexact_o;
    endtask

    logic [23:0] m;
    logic [7:0]  e;
    logic        so, ovf, inx;
    int          lat;

    typedef struct {
        string       tag;
        logic [24:0] um;
        logic [23:0] irb;
        logic [8:0]  ex;
        logic        s;
        logic [1:0]  rm;
        logic [23:0] em;
        logic [7:0]  ee;
        logic        eovf;
        logic        einx;
    } vec_t;

    vec_t vecs[$];

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drive(25'h0, 24'h0, 9'd0, 1'b0, 2'd0);
        in_valid = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_m", {40'b0, resulted_m_o}, 64'd0);
        chk("rst_e", {56'b0, resulted_e_o}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);

        // tag, um, irb, exp, sign, mode, m, e, ovf, inexact
        vecs.push_back('{"norm0",     25'h1000000, 24'h0, 9'd130, 1'b0, 2'd0, 24'h800000, 8'd131, 1'b0, 1'b0});
        vecs.push_back('{"norm1",     25'h0800000, 24'h0, 9'd130, 1'b0, 2'd0, 24'h800000, 8'd130, 1'b0, 1'b0});
        vecs.push_back('{"norm2",     25'h0400000, 24'h0, 9'd130, 1'b0, 2'd0, 24'h800000, 8'd129, 1'b0, 1'b0});
        vecs.push_back('{"rne_tie_e", 25'h1000001, 24'h0, 9'd100, 1'b0, 2'd0, 24'h800000, 8'd101, 1'b0, 1'b1});
        vecs.push_back('{"rup",       25'h1000001, 24'h0, 9'd100, 1'b0, 2'd2, 24'h800001, 8'd101, 1'b0, 1'b1});
        vecs.push_back('{"rtz",       25'h1000001, 24'h0, 9'd100, 1'b0, 2'd1, 24'h800000, 8'd101, 1'b0, 1'b1});
        vecs.push_back('{"rdn_neg",   25'h1000001, 24'h0, 9'd100, 1'b1, 2'd3, 24'h800001, 8'd101, 1'b0, 1'b1});
        vecs.push_back('{"rdn_pos",   25'h1000001, 24'h0, 9'd100, 1'b0, 2'd3, 24'h800000, 8'd101, 1'b0, 1'b1});
        vecs.push_back('{"rne_tie_o", 25'h1000003, 24'h0, 9'd100, 1'b0, 2'd0, 24'h800002, 8'd101, 1'b0, 1'b1});
        vecs.push_back('{"rup_stky",  25'h1000000, 24'h1, 9'd100, 1'b0, 2'd2, 24'h800001, 8'd101, 1'b0, 1'b1});
        vecs.push_back('{"carry",     25'h1FFFFFF, 24'h0, 9'd100, 1'b0, 2'd0, 24'h800000, 8'd102, 1'b0, 1'b1});
        vecs.push_back('{"ovf",       25'h1FFFFFF, 24'h0, 9'd253, 1'b0, 2'd0, 24'h800000, 8'hFF,  1'b1, 1'b1});
        vecs.push_back('{"ovf_edge",  25'h1000000, 24'h0, 9'd254, 1'b1, 2'd0, 24'h800000, 8'hFF,  1'b1, 1'b1});
        vecs.push_back('{"below_ovf", 25'h1000000, 24'h0, 9'd253, 1'b0, 2'd0, 24'h800000, 8'd254, 1'b0, 1'b0});

        foreach (vecs[i]) begin
            run_op(vecs[i].um, vecs[i].irb, vecs[i].ex, vecs[i].s, vecs[i].rm, m, e, so, ovf, inx, lat);
            chk({vecs[i].tag, "_lat"}, lat, 2);
            chk({vecs[i].tag, "_m"}, {40'b0, m}, {40'b0, vecs[i].em});
            chk({vecs[i].tag, "_e"}, {56'b0, e}, {56'b0, vecs[i].ee});
            chk({vecs[i].tag, "_sign"}, {63'b0, so}, {63'b0, vecs[i].s});
            chk({vecs[i].tag, "_ovf"}, {63'b0, ovf}, {63'b0, vecs[i].eovf & FLAGS});
            chk({vecs[i].tag, "_inx"}, {63'b0, inx}, {63'b0, vecs[i].einx & FLAGS});
        end

        // Back-pressure: 4 ops, out_ready low for the first 5 cycles.
        begin
            int          idx = 0;
            int          n_out = 0;
            bit          saw_full = 0;
            bit          held = 0;
            int          n_unstable = 0;
            logic [23:0] hold_m;
            logic [7:0]  hold_e;
            @(negedge clk);
            for (int cyc = 0; cyc < 40; cyc++) begin
                out_ready = (cyc >= 5);
                if (idx < 4) drive(25'h1000000, 24'h0, 9'(10 + idx), idx[0], 2'd0);
                else         in_valid = 1'b0;
                #1;
                if (out_valid && !out_ready) begin
                    if (!held) begin
                        held   = 1;
                        hold_m = resulted_m_o;
                        hold_e = resulted_e_o;
                    end else if (resulted_m_o !== hold_m || resulted_e_o !== hold_e) begin
                        n_unstable++;
                    end
                end
                if (out_valid && out_ready) begin
                    if (n_out < 4) begin
                        chk($sformatf("bp_order%0d", n_out), {56'b0, resulted_e_o}, 64'(11 + n_out));
                        chk($sformatf("bp_sign%0d", n_out), {63'b0, sign_o}, 64'(n_out % 2));
                    end
                    n_out++;
                end
                if (idx < 4) begin
                    if (in_ready) idx++;
                    else          saw_full = 1;
                end
                @(negedge clk);
            end
            in_valid = 1'b0;
            chk("bp_in_ready_drop", {63'b0, saw_full}, 64'd1);
            chk("bp_head_stable", n_unstable, 64'd0);
            chk("bp_count", n_out, 64'd4);
        end

        // Reset with two operations in flight.
        begin
            int stale = 0;
            out_ready = 1'b1;
            @(negedge clk);
            drive(25'h1000000, 24'h0, 9'd50, 1'b0, 2'd0);
            @(negedge clk);
            drive(25'h1000000, 24'h0, 9'd51, 1'b0, 2'd0);
            @(negedge clk);
            in_valid = 1'b0;
            chk("mid_pre_valid", {63'b0, out_valid}, 64'd1);
            #2 rst = 1'b1;
            #1;
            chk("mid_rst_valid", {63'b0, out_valid}, 64'd0);
            chk("mid_rst_e", {56'b0, resulted_e_o}, 64'd0);
            @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (out_valid) stale++;
            end
            chk("mid_no_stale", stale, 64'd0);
            run_op(25'h0800000, 24'h0, 9'd77, 1'b0, 2'd0, m, e, so, ovf, inx, lat);
            chk("post_rst_lat", lat, 2);
            chk("post_rst_e", {56'b0, e}, 64'd77);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/far_path_pipe.md
FAR_PATH_PIPE -- requirements
Module: far_path_pipe

Interface
REQ-001 Parameter SIZE_IN_MANTISSA, default 24, is the input mantissa width including the hidden bit (1.M).
REQ-002 Parameter SIZE_OUT_MANTISSA, default 24, is the output mantissa width including the hidden bit.
REQ-003 Parameter SIZE_EXPONENT, default 8, is the biased exponent width.
REQ-004 Parameter STAGES, default 2, is the pipeline depth; legal values are 1..3, and any other value SHALL fail elaboration.
REQ-005 Port list (name, direction, width, meaning), one per line:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept an operand.
- unnormalized_mantissa  in  SIZE_IN_MANTISSA+1  sum/difference of the aligned mantissas.
- inter_rounding_bits  in  SIZE_IN_MANTISSA  bits shifted out during alignment.
- exp_inter  in  SIZE_EXPONENT+1  intermediate exponent.
- sign_i  in  1  result sign.
- round_mode  in  2  rounding mode: 0=RNE, 1=RTZ, 2=RUP, 3=RDN.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- resulted_m_o  out  SIZE_OUT_MANTISSA  rounded mantissa.
- resulted_e_o  out  SIZE_EXPONENT  result exponent.
- sign_o  out  1  result sign.
- overflow_o, inexact_o  out  1 each  exception flags (see REQ-020).

Function
REQ-006 The adjust amount SHALL be 0 if unnormalized_mantissa[MSB] is 1, else 1 if unnormalized_mantissa[MSB-1] is 1, else 2.
REQ-007 The normalised vector SHALL be {unnormalized_mantissa, inter_rounding_bits} shifted left by the adjust amount and zero-filled.
REQ-008 Rounding operands: the top SIZE_OUT_MANTISSA bits of the normalised vector are the kept bits, the next bit is the guard bit G, and the OR of all remaining bits is the sticky bit S.
REQ-009 Increment rule per mode:
- RNE: increment if G & (S | LSB).
- RTZ: never increment.
- RUP: increment if (G | S) & ~sign.
- RDN: increment if (G | S) & sign.
REQ-010 Exponent: resulted_e = exp_inter - adjust + 1.
REQ-011 Mantissa rounding carry-out: mantissa becomes 1 followed by zeros, and the exponent is incremented by one more.
REQ-012 If the final exponent is >= 2^SIZE_EXPONENT-1: exponent becomes all ones, mantissa becomes 1 followed by zeros (infinity), and overflow is asserted.
REQ-013 Handshake: a transfer occurs on a clk edge where valid & ready are both high, on each side independently.
REQ-014 Pipeline is elastic:
- Each stage register loads when it is empty or its downstream stage advances.
- in_ready = stage-1 empty OR pipeline advancing; in_ready SHALL be combinationally dependent on out_ready.
REQ-015 With out_ready held high, latency from input transfer to out_valid SHALL be exactly STAGES cycles, and throughput SHALL be one operation per cycle.
REQ-016 While out_valid=1 and out_ready=0, every output SHALL hold stable; no operation is lost, duplicated or reordered.
REQ-017 Stage split:
- STAGES=3: normalise | round | exponent/flags.
- STAGES=2: normalise | round+exponent.
- STAGES=1: all logic feeds a single output register.
REQ-018 round_mode and sign_i SHALL be captured with their operand and travel through the pipeline with it.

Reset
REQ-019 On rst high, all valid bits, resulted_m_o, resulted_e_o, sign_o and the flags SHALL clear to 0 asynchronously; in_ready SHALL be 1 from the first edge after rst is released; operations in flight at reset are discarded.

Configuration
REQ-020 Macro FAR_PATH_EXC_FLAGS_EN:
- Defined: overflow_o = REQ-012 condition; inexact_o = G|S|overflow; both registered alongside the data.
- Undefined: both ports SHALL be tied to 0 and the saturation of REQ-012 still applies.

Structure
REQ-021 Package far_path_pkg SHALL hold the round-mode enumeration (RNE, RTZ, RUP, RDN) and the adjust-amount width constant.
REQ-022 Sub-module far_path_round SHALL be purely combinational: kept bits, G, S, mode and sign in; rounded mantissa and carry out.

Verification (SIZE_IN_MANTISSA=24, SIZE_OUT_MANTISSA=24, SIZE_EXPONENT=8, STAGES=2)
REQ-023 um=25'h1000000, irb=0, exp=130, RNE -> m=24'h800000, e=131, inexact=0, out_valid exactly 2 cycles after accept.
REQ-024 um=25'h0800000, irb=0, exp=130 -> m=24'h800000, e=130 (adjust=1).
REQ-025 um=25'h1000001, irb=0, exp=100, sign 0:
- RNE -> m=24'h800000, e=101, inexact=1.
- RUP -> m=24'h800001.
- RTZ -> m=24'h800000.
REQ-026 um=25'h1FFFFFF, irb=0, exp=100, RNE -> m=24'h800000, e=102 (rounding carry); same operand with exp=253 -> e=8'hFF, m=24'h800000, overflow=1.
REQ-027 Back-pressure and order:
- Stream 4 ops back-to-back while holding out_ready=0 for 5 cycles.
- Required: in_ready drops when full, the head result stays stable, then all 4 results emerge in order with none lost.
REQ-028 Reset mid-operation: assert rst with 2 ops in flight -> out_valid=0 immediately; no stale result appears after release.
